// File: rtl/pipelined_adder.sv
// pipelined_adder: CHUNK-bit-per-stage pipelined add/subtract with overflow flag and valid/ready stall
module pipelined_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int STAGES = WIDTH / CHUNK;

    logic w_adv;

    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv;

    genvar k;
    for (k = 0; k < STAGES; k++) begin : g_st
        localparam int UW = WIDTH - k * CHUNK;
        logic                   w_vld;
        logic                   w_c;
        logic [UW-1:0]          w_a;
        logic [UW-1:0]          w_b;
        logic [CHUNK:0]         w_t;
        logic [(k+1)*CHUNK-1:0] w_s;
        logic                   r_vld;
        logic                   r_c;
        logic [(k+1)*CHUNK-1:0] r_s;
        if (k == 0) begin : g_src
            assign w_vld = in_valid;
            assign w_a   = a;
            assign w_b   = sub ? ~b : b;
            assign w_c   = sub | cin;
            assign w_s   = w_t[CHUNK-1:0];
        end else begin : g_src
            assign w_vld = g_st[k-1].r_vld;
            assign w_a   = g_st[k-1].g_op.r_a;
            assign w_b   = g_st[k-1].g_op.r_b;
            assign w_c   = g_st[k-1].r_c;
            assign w_s   = {w_t[CHUNK-1:0], g_st[k-1].r_s};
        end
        assign w_t = {1'b0, w_a[CHUNK-1:0]} + {1'b0, w_b[CHUNK-1:0]} + {{CHUNK{1'b0}}, w_c};
        // Valid bit, chunk carry and resolved sum bits advance together on a global stall-free cycle
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_vld <= 1'b0;
                r_c   <= 1'b0;
                r_s   <= '0;
            end else if (w_adv) begin
                r_vld <= w_vld;
                r_c   <= w_t[CHUNK];
                r_s   <= w_s;
            end
        end
        if (k < STAGES - 1) begin : g_op
            logic [UW-CHUNK-1:0] r_a;
            logic [UW-CHUNK-1:0] r_b;
            // Unresolved upper operand chunks (including sign bits) travel with the beat
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_adv) begin
                    r_a <= w_a[UW-1:CHUNK];
                    r_b <= w_b[UW-1:CHUNK];
                end
            end
        end else begin : g_ov
            logic r_ovf;
            // The top chunk still holds both operand sign bits, so overflow is resolved here
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_ovf <= 1'b0;
                end else if (w_adv) begin
                    r_ovf <= (w_a[UW-1] == w_b[UW-1]) && (w_t[CHUNK-1] != w_a[UW-1]);
                end
            end
        end
    end

    assign out_valid = g_st[STAGES-1].r_vld;
    assign sum       = g_st[STAGES-1].r_s;
    assign cout      = g_st[STAGES-1].r_c;
    assign ovf       = g_st[STAGES-1].g_ov.r_ovf;
endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: scoreboard bench for pipelined_adder (WIDTH=16, CHUNK=4)
module tb_pipelined_adder;
    typedef struct packed {
        logic [15:0] s;
        logic        c;
        logic        v;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        cin = 1'b0;
    logic        sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    exp_t        q[$];
    exp_t        exp_cur = '0;
    exp_t        e;
    int          checks = 0;
    int          failures = 0;
    int          in_n = 0;
    int          out_n = 0;
    logic        held = 1'b0;
    logic [18:0] hold_v = '0;

    always #5 clk = ~clk;

    pipelined_adder #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    function automatic exp_t ex(input logic [15:0] s, input logic c, input logic v);
        exp_t r;
        r.s = s;
        r.c = c;
        r.v = v;
        return r;
    endfunction

    function automatic exp_t model(input logic [15:0] ma, input logic [15:0] mb, input logic mc, input logic ms);
        logic [15:0] be;
        logic [16:0] t;
        be = ms ? ~mb : mb;
        t  = {1'b0, ma} + {1'b0, be} + {16'd0, ms ? 1'b1 : mc};
        return ex(t[15:0], t[16], (ma[15] == be[15]) && (t[15] != ma[15]));
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic send(input logic [15:0] sa, input logic [15:0] sb, input logic sc, input logic ss, input exp_t se);
        logic acc;
        a = sa;
        b = sb;
        cin = sc;
        sub = ss;
        exp_cur = se;
        in_valid = 1'b1;
        acc = 1'b0;
        for (int t = 0; t < 100 && !acc; t++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL send_timeout a=%h b=%h never accepted", sa, sb);
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int t = 0; t < 60 && q.size() != 0; t++) begin
            @(posedge clk);
            #1;
        end
        chk("drain_queue_left", q.size(), 0);
    endtask

    // Record each accepted beat's expected result in acceptance order
    always @(negedge clk) begin
        if (rst_n && in_valid && in_ready) begin
            q.push_back(exp_cur);
            in_n++;
        end
    end

    // Compare every consumed result and check handshake/hold behaviour
    always @(negedge clk) begin
        if (!rst_n) begin
            held = 1'b0;
        end else begin
            chk("in_ready", {31'd0, in_ready}, {31'd0, !out_valid || out_ready});
            if (held) chk("hold_stable", {13'd0, out_valid, sum, cout, ovf}, {13'd0, hold_v});
            held = out_valid && !out_ready;
            hold_v = {out_valid, sum, cout, ovf};
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL stale_beat sum=%h cout=%b ovf=%b with nothing expected", sum, cout, ovf);
                end else begin
                    e = q.pop_front();
                    chk("result", {14'd0, sum, cout, ovf}, {14'd0, e.s, e.c, e.v});
                    out_n++;
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            cin = 1'($urandom);
            sub = 1'($urandom);
            in_valid = 1'($urandom);
            out_ready = 1'($urandom);
            @(negedge clk);
            chk("reset_out_valid", {31'd0, out_valid}, 0);
            chk("reset_sum", {16'd0, sum}, 0);
            chk("reset_cout", {31'd0, cout}, 0);
            chk("reset_ovf", {31'd0, ovf}, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1 chk("in_ready_after_reset", {31'd0, in_ready}, 1);
        @(posedge clk);
        #1;
        send(16'h0001, 16'h0001, 1'b0, 1'b0, ex(16'h0002, 1'b0, 1'b0));
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1 chk("latency_early", {31'd0, out_valid}, 0);
        end
        @(posedge clk);
        #1 chk("latency_due", {31'd0, out_valid}, 1);
        send(16'h0007, 16'h0001, 1'b1, 1'b0, ex(16'h0009, 1'b0, 1'b0));
        send(16'hFFFF, 16'h0001, 1'b1, 1'b0, ex(16'h0001, 1'b1, 1'b0));
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, ex(16'h8000, 1'b0, 1'b1));
        send(16'h0005, 16'h0007, 1'b1, 1'b1, ex(16'hFFFE, 1'b0, 1'b0));
        send(16'h8000, 16'h0001, 1'b0, 1'b1, ex(16'h7FFF, 1'b1, 1'b1));
        send(16'h0000, 16'h0000, 1'b0, 1'b1, ex(16'h0000, 1'b1, 1'b0));
        send(16'h1234, 16'h4321, 1'b0, 1'b0, ex(16'h5555, 1'b0, 1'b0));
        send(16'h8000, 16'h8000, 1'b0, 1'b0, ex(16'h0000, 1'b1, 1'b1));
        drain();

        fork
            for (int i = 0; i < 8; i++)
                send(16'(i * 16'h1111), 16'h0F0F, 1'(i), 1'(i >> 1), model(16'(i * 16'h1111), 16'h0F0F, 1'(i), 1'(i >> 1)));
            begin
                for (int t = 0; t < 50 && !out_valid; t++) @(negedge clk);
                @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        for (int i = 0; i < 5; i++) send(16'(i + 3), 16'(i * 7), 1'b0, 1'b0, model(16'(i + 3), 16'(i * 7), 1'b0, 1'b0));
        #2 rst_n = 1'b0;
        q.delete();
        in_n = 0;
        out_n = 0;
        #1;
        chk("midreset_out_valid", {31'd0, out_valid}, 0);
        chk("midreset_sum", {16'd0, sum}, 0);
        chk("midreset_cout_ovf", {30'd0, cout, ovf}, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1 chk("no_stale_after_reset", {31'd0, out_valid}, 0);

        for (int i = 0; i < 18000; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            cin = 1'($urandom);
            sub = 1'($urandom);
            exp_cur = model(a, b, cin, sub);
            in_valid = $urandom_range(0, 7) != 0;
            out_ready = $urandom_range(0, 7) != 0;
            @(posedge clk);
            #1;
        end
        drain();
        chk("beat_count", out_n, in_n);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
